// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: op codes, FSM encoding,
// request payload and default timeout.
package alu_pkg;

  localparam int unsigned OP_W            = 2;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned DATA_W          = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 63;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_MUL = 2'b10;
  localparam logic [OP_W-1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_LOAD0 = 3'd2,
    ST_LOAD1 = 3'd3,
    ST_LOAD2 = 3'd4,
    ST_WAIT  = 3'd5,
    ST_CAP1  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [BYTE_W-1:0] b;
  } req_t;

  // mul and div return two result bytes, add and sub only one
  function automatic logic is_wide(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between a requester (master) and the
// ALU operation sequencer (slave).
interface alu_op_sequencer_if;
  import alu_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [OP_W-1:0]     req_op;
  logic [DATA_W-1:0]   req_a;
  logic [BYTE_W-1:0]   req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_result;
  logic                rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );

endinterface

// File: rtl/alu_seq_timer.sv
// Loadable down-counter that bounds how long the sequencer waits for the ALU.
module alu_seq_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired_c = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one add/sub/mul/div request through a byte-serial ALU: clear,
// load operands, wait for completion (with timeout), then hold the response.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  alu_op_sequencer_if.slave bus,
  output logic              alu_reset,
  output logic              alu_begin,
  output logic [OP_W-1:0]   alu_op_code,
  output logic [BYTE_W-1:0] alu_inbus,
  input  logic [BYTE_W-1:0] alu_outbus,
  input  logic              alu_end
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state, state_nxt;
  req_t                req_q, req_nxt;
  logic [DATA_W-1:0]   result_nxt;
  logic                err_nxt;
  logic                req_ready_nxt, rsp_valid_nxt;
  logic                alu_reset_nxt, alu_begin_nxt;
  logic [OP_W-1:0]     alu_op_code_nxt;
  logic [BYTE_W-1:0]   alu_inbus_nxt;
  logic                timer_load;
  logic                timeout_c;
  logic                accept_c;

  assign accept_c = (state == ST_IDLE) && bus.req_valid && bus.req_ready;

  // the counter runs only in WAIT; expiry ends the transaction with an error
  alu_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_val  (CNT_W'(TIMEOUT - 1)),
    .en        (state == ST_WAIT),
    .expired_c (timeout_c)
  );

  // next state and result capture, then outputs decoded from the next state
  always_comb begin
    state_nxt       = state;
    req_nxt         = req_q;
    result_nxt      = bus.rsp_result;
    err_nxt         = bus.rsp_err;
    timer_load      = 1'b0;
    req_ready_nxt   = 1'b0;
    rsp_valid_nxt   = 1'b0;
    alu_reset_nxt   = 1'b0;
    alu_begin_nxt   = 1'b0;
    alu_op_code_nxt = '0;
    alu_inbus_nxt   = '0;

    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          req_nxt.op = bus.req_op;
          req_nxt.a  = bus.req_a;
          req_nxt.b  = bus.req_b;
          result_nxt = '0;
          err_nxt    = 1'b0;
          if ((bus.req_op == OP_DIV) && (bus.req_b == '0)) begin
            result_nxt = '1;
            err_nxt    = 1'b1;
            state_nxt  = ST_DONE;
          end else begin
            state_nxt  = ST_CLR;
          end
        end
      end
      ST_CLR:   state_nxt = ST_LOAD0;
      ST_LOAD0: state_nxt = ST_LOAD1;
      ST_LOAD1: begin
        if (req_q.op == OP_DIV) begin
          state_nxt = ST_LOAD2;
        end else begin
          state_nxt  = ST_WAIT;
          timer_load = 1'b1;
        end
      end
      ST_LOAD2: begin
        state_nxt  = ST_WAIT;
        timer_load = 1'b1;
      end
      ST_WAIT: begin
        if (alu_end) begin
          if (is_wide(req_q.op)) begin
            result_nxt[15:8] = alu_outbus;
            state_nxt        = ST_CAP1;
          end else begin
            result_nxt = {8'h00, alu_outbus};
            state_nxt  = ST_DONE;
          end
        end else if (timeout_c) begin
          result_nxt = '0;
          err_nxt    = 1'b1;
          state_nxt  = ST_DONE;
        end
      end
      ST_CAP1: begin
        result_nxt[7:0] = alu_outbus;
        state_nxt       = ST_DONE;
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    case (state_nxt)
      ST_IDLE: req_ready_nxt = 1'b1;
      ST_CLR: begin
        alu_reset_nxt   = 1'b1;
        alu_op_code_nxt = req_nxt.op;
      end
      ST_LOAD0: begin
        alu_begin_nxt   = 1'b1;
        alu_op_code_nxt = req_nxt.op;
        alu_inbus_nxt   = (req_nxt.op == OP_DIV) ? req_nxt.a[15:8] : req_nxt.a[7:0];
      end
      ST_LOAD1: begin
        alu_op_code_nxt = req_nxt.op;
        alu_inbus_nxt   = (req_nxt.op == OP_DIV) ? req_nxt.a[7:0] : req_nxt.b;
      end
      ST_LOAD2: begin
        alu_op_code_nxt = req_nxt.op;
        alu_inbus_nxt   = req_nxt.b;
      end
      ST_WAIT, ST_CAP1: alu_op_code_nxt = req_nxt.op;
      ST_DONE: rsp_valid_nxt = 1'b1;
      default: ;
    endcase
  end

  // state, request and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      req_q          <= '0;
      bus.req_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_err    <= 1'b0;
      alu_reset      <= 1'b0;
      alu_begin      <= 1'b0;
      alu_op_code    <= '0;
      alu_inbus      <= '0;
    end else begin
      state          <= state_nxt;
      req_q          <= req_nxt;
      bus.req_ready  <= req_ready_nxt;
      bus.rsp_valid  <= rsp_valid_nxt;
      bus.rsp_result <= result_nxt;
      bus.rsp_err    <= err_nxt;
      alu_reset      <= alu_reset_nxt;
      alu_begin      <= alu_begin_nxt;
      alu_op_code    <= alu_op_code_nxt;
      alu_inbus      <= alu_inbus_nxt;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a byte-serial ALU stub.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_reset, alu_begin;
  logic [1:0]  alu_op_code;
  logic [7:0]  alu_inbus;
  logic [7:0]  alu_outbus;
  logic        alu_end;

  int tests = 0;
  int fails = 0;
  bit stub_mute = 1'b0;
  bit force_end = 1'b0;

  always #5 clk = ~clk;

  alu_op_sequencer_if bus();

  alu_op_sequencer #(.TIMEOUT(63)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .alu_reset   (alu_reset),
    .alu_begin   (alu_begin),
    .alu_op_code (alu_op_code),
    .alu_inbus   (alu_inbus),
    .alu_outbus  (alu_outbus),
    .alu_end     (alu_end)
  );

  // ALU stub: collects operand bytes after alu_begin, answers a few cycles later
  int          sph = 0;
  int          swait = 0;
  logic [1:0]  sop;
  logic [7:0]  sb0, sb1, sb2;
  logic [15:0] sres;

  function automatic logic [15:0] alu_model(input logic [1:0] op, input logic [7:0] b0,
                                            input logic [7:0] b1, input logic [7:0] b2);
    logic [15:0] dvd;
    logic [15:0] q, r;
    dvd = {b0, b1};
    case (op)
      OP_ADD:  return {8'h00, 8'(b0 + b1)};
      OP_SUB:  return {8'h00, 8'(b0 - b1)};
      OP_MUL:  return 16'(16'(b0) * 16'(b1));
      default: begin
        q = dvd / 16'(b2);
        r = dvd % 16'(b2);
        return {q[7:0], r[7:0]};
      end
    endcase
  endfunction

  initial begin
    alu_end    = 1'b0;
    alu_outbus = 8'h00;
  end

  always @(posedge clk) begin
    #2;
    alu_end = force_end;
    if (!reset) begin
      sph = 0;
      alu_outbus = 8'h00;
    end else if (alu_reset) begin
      sph = 0;
    end else if (alu_begin) begin
      sop = alu_op_code;
      sb0 = alu_inbus;
      sph = 1;
    end else if (sph == 1) begin
      sb1 = alu_inbus;
      if (sop == OP_DIV) sph = 2;
      else begin
        sres = alu_model(sop, sb0, sb1, 8'h00);
        swait = 2;
        sph = 4;
      end
    end else if (sph == 2) begin
      sb2 = alu_inbus;
      sres = alu_model(sop, sb0, sb1, sb2);
      swait = 2;
      sph = 4;
    end else if (sph == 4) begin
      if (swait > 0) swait--;
      else if (!stub_mute) begin
        alu_end = 1'b1;
        alu_outbus = is_wide(sop) ? sres[15:8] : sres[7:0];
        sph = is_wide(sop) ? 5 : 0;
      end
    end else if (sph == 5) begin
      alu_outbus = sres[7:0];
      sph = 0;
    end
  end

  // drive a request at a negedge in IDLE; returns at the negedge of T+1
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n, output bit to);
    n  = 0;
    to = 1'b0;
    while (!bus.rsp_valid) begin
      if (n >= 200) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = 16'h0000;
    bus.req_b     = 8'h00;
    bus.rsp_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, alu_reset, alu_begin} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctl: got %b expected 00000",
               {bus.req_ready, bus.rsp_valid, bus.rsp_err, alu_reset, alu_begin});
    end
    tests++;
    if ({alu_op_code, alu_inbus, bus.rsp_result} !== 26'h0) begin
      fails++;
      $display("FAIL reset_data: got %h expected 0", {alu_op_code, alu_inbus, bus.rsp_result});
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 1", bus.req_ready);
    end
  endtask

  task automatic test_add_back_to_back();
    int n;
    bit to;
    issue(OP_ADD, 16'h0038, 8'h59);
    tests++;
    if ({alu_reset, alu_op_code, bus.req_ready} !== {1'b1, OP_ADD, 1'b0}) begin
      fails++;
      $display("FAIL add_clr: got %b expected 1000", {alu_reset, alu_op_code, bus.req_ready});
    end
    @(negedge clk);
    tests++;
    if ({alu_begin, alu_inbus} !== {1'b1, 8'h38}) begin
      fails++;
      $display("FAIL add_load0: got %h expected 138", {alu_begin, alu_inbus});
    end
    @(negedge clk);
    tests++;
    if ({alu_reset, alu_begin, alu_inbus} !== {2'b00, 8'h59}) begin
      fails++;
      $display("FAIL add_load1: got %h expected 059", {alu_reset, alu_begin, alu_inbus});
    end
    @(negedge clk);
    tests++;
    if (alu_inbus !== 8'h00) begin
      fails++;
      $display("FAIL add_wait_inbus: got %h expected 00", alu_inbus);
    end
    wait_rsp(n, to);
    tests++;
    if ({to, n} !== {1'b0, 32'd3}) begin
      fails++;
      $display("FAIL add_latency: got timeout=%b cycles=%0d expected timeout=0 cycles=3", to, n);
    end
    tests++;
    if ({bus.rsp_err, bus.rsp_result} !== {1'b0, 16'h0091}) begin
      fails++;
      $display("FAIL add_result: got err=%b res=%h expected err=0 res=0091", bus.rsp_err, bus.rsp_result);
    end
    // request already waiting while the response is taken
    bus.req_valid = 1'b1;
    bus.req_op    = OP_ADD;
    bus.req_a     = 16'h0001;
    bus.req_b     = 8'h02;
    bus.rsp_ready = 1'b1;
    tests++;
    if (bus.req_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done_ready: got %b expected 0", bus.req_ready);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    tests++;
    if ({bus.rsp_valid, bus.req_ready, alu_reset} !== 3'b010) begin
      fails++;
      $display("FAIL b2b_idle: got %b expected 010", {bus.rsp_valid, bus.req_ready, alu_reset});
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    tests++;
    if (alu_reset !== 1'b1) begin
      fails++;
      $display("FAIL b2b_clr: got %b expected 1", alu_reset);
    end
    wait_rsp(n, to);
    tests++;
    if ({to, bus.rsp_err, bus.rsp_result} !== {2'b00, 16'h0003}) begin
      fails++;
      $display("FAIL b2b_result: got to=%b err=%b res=%h expected to=0 err=0 res=0003",
               to, bus.rsp_err, bus.rsp_result);
    end
    take_rsp();
  endtask

  task automatic test_sub_hold();
    int n;
    bit to;
    issue(OP_SUB, 16'h0038, 8'h59);
    wait_rsp(n, to);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({to, bus.rsp_valid, bus.rsp_err, bus.rsp_result} !== {3'b010, 16'h00DF}) begin
        fails++;
        $display("FAIL sub_hold[%0d]: got to=%b valid=%b err=%b res=%h expected 0 1 0 00DF",
                 i, to, bus.rsp_valid, bus.rsp_err, bus.rsp_result);
      end
      @(negedge clk);
    end
    take_rsp();
    tests++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      fails++;
      $display("FAIL sub_release: got %b expected 01", {bus.rsp_valid, bus.req_ready});
    end
  endtask

  task automatic test_mul_ignore_end();
    int n;
    bit to;
    force_end = 1'b1;
    issue(OP_MUL, 16'h0038, 8'h59);
    repeat (2) @(negedge clk);
    force_end = 1'b0;
    tests++;
    if ({alu_op_code, alu_inbus} !== {OP_MUL, 8'h59}) begin
      fails++;
      $display("FAIL mul_load1: got %h expected 259", {alu_op_code, alu_inbus});
    end
    wait_rsp(n, to);
    tests++;
    if ({to, bus.rsp_err, bus.rsp_result} !== {2'b00, 16'h1378}) begin
      fails++;
      $display("FAIL mul_result: got to=%b err=%b res=%h expected to=0 err=0 res=1378",
               to, bus.rsp_err, bus.rsp_result);
    end
    take_rsp();
  endtask

  task automatic test_div();
    int n;
    bit to;
    issue(OP_DIV, 16'h127B, 8'h59);
    tests++;
    if ({alu_reset, alu_op_code} !== {1'b1, OP_DIV}) begin
      fails++;
      $display("FAIL div_clr: got %b expected 111", {alu_reset, alu_op_code});
    end
    @(negedge clk);
    tests++;
    if ({alu_begin, alu_inbus} !== {1'b1, 8'h12}) begin
      fails++;
      $display("FAIL div_load0: got %h expected 112", {alu_begin, alu_inbus});
    end
    @(negedge clk);
    tests++;
    if ({alu_begin, alu_inbus} !== {1'b0, 8'h7B}) begin
      fails++;
      $display("FAIL div_load1: got %h expected 07B", {alu_begin, alu_inbus});
    end
    @(negedge clk);
    tests++;
    if ({alu_begin, alu_inbus} !== {1'b0, 8'h59}) begin
      fails++;
      $display("FAIL div_load2: got %h expected 059", {alu_begin, alu_inbus});
    end
    wait_rsp(n, to);
    tests++;
    if ({to, bus.rsp_err, bus.rsp_result} !== {2'b00, 16'h350E}) begin
      fails++;
      $display("FAIL div_result: got to=%b err=%b res=%h expected to=0 err=0 res=350E",
               to, bus.rsp_err, bus.rsp_result);
    end
    take_rsp();
  endtask

  task automatic test_div_zero();
    int alu_seen;
    issue(OP_DIV, 16'h1234, 8'h00);
    tests++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_result} !== {2'b11, 16'hFFFF}) begin
      fails++;
      $display("FAIL divz_rsp: got valid=%b err=%b res=%h expected 1 1 FFFF",
               bus.rsp_valid, bus.rsp_err, bus.rsp_result);
    end
    alu_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if ({alu_reset, alu_begin, alu_op_code, alu_inbus} !== 12'h0) alu_seen++;
      @(negedge clk);
    end
    tests++;
    if (alu_seen !== 0) begin
      fails++;
      $display("FAIL divz_alu_quiet: got %0d active cycles expected 0", alu_seen);
    end
    take_rsp();
  endtask

  task automatic test_timeout();
    int n;
    bit to;
    stub_mute = 1'b1;
    issue(OP_ADD, 16'h0001, 8'h02);
    wait_rsp(n, to);
    tests++;
    if ({to, n} !== {1'b0, 32'd66}) begin
      fails++;
      $display("FAIL tmo_latency: got timeout=%b cycles=%0d expected timeout=0 cycles=66", to, n);
    end
    tests++;
    if ({bus.rsp_err, bus.rsp_result} !== {1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL tmo_result: got err=%b res=%h expected err=1 res=0000", bus.rsp_err, bus.rsp_result);
    end
    take_rsp();
    stub_mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    stub_mute = 1'b1;
    issue(OP_MUL, 16'h0038, 8'h59);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if ({bus.rsp_valid, bus.req_ready, alu_op_code, alu_inbus, bus.rsp_result} !== 28'h0) begin
      fails++;
      $display("FAIL rst_mid_async: got %h expected 0",
               {bus.rsp_valid, bus.req_ready, alu_op_code, alu_inbus, bus.rsp_result});
    end
    @(negedge clk);
    reset = 1'b1;
    stub_mute = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    tests++;
    if ({seen, bus.req_ready} !== {32'd0, 1'b1}) begin
      fails++;
      $display("FAIL rst_mid_abandon: got rsp cycles=%0d ready=%b expected 0 1", seen, bus.req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add_back_to_back();
    test_sub_hold();
    test_mul_ignore_end();
    test_div();
    test_div_zero();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 63, max cycles spent waiting for alu_end.
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low.
REQ-004 req_valid  in  1  request present; req_ready  out  1  sequencer idle, may accept.
REQ-005 req_op  in  2  00 add, 01 sub, 10 mul, 11 div; req_a  in  16  operand A (dividend for div, else [7:0] only); req_b  in  8  operand B / divisor.
REQ-006 rsp_valid  out  1  result available; rsp_ready  in  1  consumer accepts; rsp_result  out  16  result; rsp_err  out  1  divide-by-zero or timeout.
REQ-007 alu_reset  out  1  active-high ALU clear; alu_begin  out  1; alu_op_code  out  2; alu_inbus  out  8; alu_outbus  in  8; alu_end  in  1.

Function
REQ-008 SHALL accept a request only in IDLE, on the cycle req_valid=1 and req_ready=1 (accept cycle T); req_op/req_a/req_b SHALL be registered at T.
REQ-009 SHALL implement states IDLE, CLR, LOAD0, LOAD1, LOAD2, WAIT, CAP1, DONE.
REQ-010 T+1 CLR: alu_reset=1 for exactly one cycle.
REQ-011 T+2 LOAD0: alu_begin=1, alu_inbus = req_a[15:8] for div, req_a[7:0] otherwise.
REQ-012 T+3 LOAD1: alu_begin=0, alu_inbus = req_a[7:0] for div, req_b otherwise; next LOAD2 for div, WAIT otherwise.
REQ-013 LOAD2 (div only, T+4): alu_inbus = req_b; next WAIT.
REQ-014 alu_op_code SHALL hold the registered op from CLR through CAP1; alu_inbus=0 outside LOAD states; alu_begin=1 only in LOAD0.
REQ-015 WAIT: on alu_end=1, capture alu_outbus; add/sub -> result {8'h00, byte}, go DONE; mul/div -> result[15:8]=byte, go CAP1.
REQ-016 CAP1: result[7:0]=alu_outbus (product low / remainder), go DONE; mul result = product, div result = {quotient, remainder}.
REQ-017 Timeout: WAIT counter cleared on entry; if TIMEOUT cycles pass without alu_end, go DONE with result 16'h0000, rsp_err=1.
REQ-018 Div with req_b=0: at T go directly to DONE (no CLR/LOAD), result 16'hFFFF, rsp_err=1, ALU outputs untouched.
REQ-019 DONE: rsp_valid=1, rsp_result/rsp_err stable until rsp_valid&&rsp_ready; then IDLE next cycle.
REQ-020 req_ready=1 only in IDLE; no back-to-back accept in the DONE->IDLE handoff cycle.
REQ-021 alu_end asserted outside WAIT SHALL be ignored.

Reset
REQ-022 reset=0 SHALL asynchronously force state IDLE, all outputs 0 (req_ready=1 once reset deasserts), result 0, counter 0.
REQ-023 Reset mid-transaction SHALL abandon it with no rsp_valid issued.

Structure
REQ-024 Shared package alu_pkg SHALL hold op-code constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV), state encoding, TIMEOUT default.
REQ-025 One sub-module, alu_seq_timer (loadable down-counter with expire flag), SHALL implement the WAIT timeout.

Verification
REQ-026 add 56, 89 -> alu_begin at T+2, inbus 56 then 89, rsp_result 16'h0091, rsp_err 0.
REQ-027 sub 56, 89 -> rsp_result 16'h00DF, rsp_err 0.
REQ-028 mul 56, 89 -> rsp_result 16'h1378 (4984), rsp_err 0.
REQ-029 div A=16'h127B (4731), B=89 -> inbus 8'h12, 8'h7B, 8'h59 at T+2..T+4; rsp_result 16'h350E (53 r 14).
REQ-030 div B=0 -> rsp_valid at T+1, rsp_result 16'hFFFF, rsp_err 1, alu_reset/alu_begin never asserted; ALU stub never raising alu_end -> rsp_err 1, result 0 after 63 WAIT cycles.
REQ-031 reset=0 during WAIT, then rsp_ready held 0 in DONE for 5 cycles -> abandoned op yields no response; held response stays stable until accepted.
